// File: rtl/add_accum_ctrl_if.sv
// Operand and result valid/ready streams plus burst start/length for add_accum_ctrl.
// The controller takes the slave modport and the stimulus/consumer side takes the master modport.
interface add_accum_ctrl_if #(
    parameter int unsigned DataWidth = 8,
    parameter int unsigned CountW    = 8
) ();
    logic                 start;
    logic [CountW-1:0]    len;
    logic [DataWidth-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [DataWidth-1:0] result;
    logic                 result_valid;
    logic                 result_ready;

    modport master (
        output start, len, in_data, in_valid, result_ready,
        input  in_ready, result, result_valid
    );

    modport slave (
        input  start, len, in_data, in_valid, result_ready,
        output in_ready, result, result_valid
    );
endinterface

// File: rtl/add_accum_ctrl.sv
// Burst accumulator wrapped around an external combinational adder; sums len stream words
// into one registered result and raises a sticky flag on unsigned wrap-around.
module add_accum_ctrl #(
    parameter int unsigned DataWidth = 8,
    parameter int unsigned CountW    = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    add_accum_ctrl_if.slave      ctrl_io,
    output logic [DataWidth-1:0] add_a_o,
    output logic [DataWidth-1:0] add_b_o,
    input  logic [DataWidth-1:0] add_sum_i,
    output logic                 ovf_o,
    output logic                 busy_o
);

    typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

    state_e               state_q, state_d;
    logic [DataWidth-1:0] acc_q, acc_d;
    logic [DataWidth-1:0] result_q, result_d;
    logic [CountW-1:0]    rem_q, rem_d;
    logic                 ovf_q, ovf_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            result_q <= '0;
            rem_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            rem_q    <= rem_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        result_d = result_q;
        rem_d    = rem_q;
        ovf_d    = ovf_q;

        unique case (state_q)
            StIdle: begin
                if (ctrl_io.start) begin
                    acc_d    = '0;
                    result_d = '0;
                    ovf_d    = 1'b0;
                    rem_d    = ctrl_io.len;
                    state_d  = (ctrl_io.len == '0) ? StDone : StAccum;
                end
            end
            StAccum: begin
                if (ctrl_io.in_valid) begin
                    acc_d    = add_sum_i;
                    result_d = add_sum_i;
                    // A modular sum smaller than the old accumulator means the carry was lost
                    ovf_d    = ovf_q | (add_sum_i < acc_q);
                    rem_d    = rem_q - CountW'(1);
                    if (rem_q == CountW'(1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (ctrl_io.result_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign add_a_o              = acc_q;
    assign add_b_o              = ctrl_io.in_data;
    assign ctrl_io.in_ready     = (state_q == StAccum);
    assign ctrl_io.result_valid = (state_q == StDone);
    assign ctrl_io.result       = result_q;
    assign ovf_o                = ovf_q;
    assign busy_o               = (state_q != StIdle);

endmodule

// File: tb/tb_add_accum_ctrl.sv
// Directed and randomized bench for add_accum_ctrl with an attached ADD model, a burst-level
// reference model checked every cycle, and literal expectations for the directed bursts.
module tb_add_accum_ctrl;
    localparam int unsigned DW = 8;
    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] add_a, add_b, add_sum;
    logic          ovf, busy;

    always #5 clk = ~clk;

    add_accum_ctrl_if #(.DataWidth(DW), .CountW(CW)) bus ();

    add_accum_ctrl #(.DataWidth(DW), .CountW(CW)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .ctrl_io   (bus),
        .add_a_o   (add_a),
        .add_b_o   (add_b),
        .add_sum_i (add_sum),
        .ovf_o     (ovf),
        .busy_o    (busy)
    );

    // The combinational ADD stage: carry discarded
    assign add_sum = add_a + add_b;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: phase of the burst and the list of words the controller has taken so far
    int          m_phase = 0;  // 0 idle, 1 taking words, 2 presenting result
    int          m_left  = 0;
    bit          m_live  = 1'b0;
    int unsigned m_words[$];

    function automatic int unsigned ref_sum();
        int unsigned s = 0;
        foreach (m_words[i]) s += m_words[i];
        return s % 256;
    endfunction

    function automatic bit ref_wrap();
        int unsigned t = 0;
        foreach (m_words[i]) begin
            if (t + m_words[i] > 255) return 1'b1;
            t = t + m_words[i];
        end
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_live  <= 1'b1;
            m_phase <= 0;
            m_left  <= 0;
            m_words.delete();
        end else if (m_phase == 0) begin
            if (bus.start) begin
                m_words.delete();
                m_left  <= int'(bus.len);
                m_phase <= (bus.len == 0) ? 2 : 1;
            end
        end else if (m_phase == 1) begin
            if (bus.in_valid) begin
                m_words.push_back(int'(bus.in_data));
                m_left <= m_left - 1;
                if (m_left == 1) m_phase <= 2;
            end
        end else if (bus.result_ready) begin
            m_phase <= 0;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("in_ready", 32'(bus.in_ready), 32'(m_phase == 1));
            check("result_valid", 32'(bus.result_valid), 32'(m_phase == 2));
            check("busy", 32'(busy), 32'(m_phase != 0));
            check("ovf", 32'(ovf), 32'(ref_wrap()));
            check("add_a", 32'(add_a), ref_sum());
            check("add_b", 32'(add_b), 32'(bus.in_data));
            if (m_phase == 2) check("result", 32'(bus.result), ref_sum());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // gap < 0 picks a random 0..2 idle cycles before each word after the first
    task automatic burst(input int n, input int unsigned w[$], input int gap, input int rdly,
                         output int unsigned res, output bit o, output int lat);
        int g;
        bus.start = 1'b1;
        bus.len   = CW'(n);
        step();
        bus.start = 1'b0;
        foreach (w[i]) begin
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            if (i > 0) begin
                repeat (g) begin
                    bus.in_valid = 1'b0;
                    bus.in_data  = DW'($urandom);
                    step();
                end
            end
            bus.in_valid = 1'b1;
            bus.in_data  = DW'(w[i]);
            step();
        end
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.result_valid && lat < 50) begin
            lat++;
            step();
        end
        if (!bus.result_valid) check("result_valid_timeout", 32'(0), 32'(1));
        res = int'(bus.result);
        o   = ovf;
        // start during DONE must be ignored
        repeat (rdly) begin
            bus.start = 1'b1;
            bus.len   = CW'(5);
            step();
        end
        bus.start        = 1'b0;
        bus.result_ready = 1'b1;
        step();
        bus.result_ready = 1'b0;
    endtask

    initial begin
        int unsigned res;
        bit          o;
        int          lat;
        int unsigned q[$];
        int unsigned s;
        bit          c;
        int          n;

        rst              = 1'b1;
        bus.start        = 1'b0;
        bus.len          = '0;
        bus.in_data      = '0;
        bus.in_valid     = 1'b0;
        bus.result_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("reset_result", 32'(bus.result), 32'(0));
        check("reset_busy", 32'(busy), 32'(0));
        check("reset_in_ready", 32'(bus.in_ready), 32'(0));

        // Basic burst 5+7+9
        burst(3, '{5, 7, 9}, 0, 0, res, o, lat);
        check("basic_result", res, 32'(21));
        check("basic_ovf", 32'(o), 32'(0));
        check("basic_latency", 32'(lat), 32'(0));
        check("idle_after_basic", 32'(bus.result_valid), 32'(0));

        // Wrap-around, then sticky flag cleared by the next start
        burst(2, '{200, 100}, 0, 0, res, o, lat);
        check("wrap_result", res, 32'(44));
        check("wrap_ovf", 32'(o), 32'(1));
        check("idle_keeps_result", 32'(bus.result), 32'(44));
        step();
        burst(1, '{1}, 0, 0, res, o, lat);
        check("after_wrap_result", res, 32'(1));
        check("after_wrap_ovf", 32'(o), 32'(0));

        // Stalled input (valid 1,0,0,1) and held-off result with start pulses in DONE
        step();
        burst(2, '{30, 40}, 2, 3, res, o, lat);
        check("stall_result", res, 32'(70));
        check("stall_ovf", 32'(o), 32'(0));
        check("stall_idle_busy", 32'(busy), 32'(0));

        // Zero length
        step();
        burst(0, '{}, 0, 0, res, o, lat);
        check("zero_result", res, 32'(0));
        check("zero_ovf", 32'(o), 32'(0));
        check("zero_latency", 32'(lat), 32'(0));

        // Reset after two of four words (which already wrapped)
        step();
        bus.start = 1'b1;
        bus.len   = CW'(4);
        step();
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = DW'(250);
        step();
        bus.in_data = DW'(10);
        step();
        bus.in_valid = 1'b0;
        check("pre_reset_ovf", 32'(ovf), 32'(1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_reset_busy", 32'(busy), 32'(0));
        check("mid_reset_result_valid", 32'(bus.result_valid), 32'(0));
        check("mid_reset_ovf", 32'(ovf), 32'(0));
        check("mid_reset_add_a", 32'(add_a), 32'(0));
        burst(1, '{3}, 0, 0, res, o, lat);
        check("post_reset_result", res, 32'(3));

        // Randomized bursts against a plain modulo-256 sum
        for (int b = 0; b < 30; b++) begin
            step();
            n = int'($urandom_range(0, 20));
            q.delete();
            s = 0;
            c = 1'b0;
            for (int i = 0; i < n; i++) begin
                q.push_back($urandom_range(0, 255));
                if (s + q[i] > 255) c = 1'b1;
                s = (s + q[i]) % 256;
            end
            burst(n, q, -1, int'($urandom_range(0, 3)), res, o, lat);
            check("rand_result", res, s);
            check("rand_ovf", 32'(o), 32'(c));
        end

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
